// File: rtl/led_matrix_pkg.sv
// Shared constants and tile-bit mapping for the 4x4 LED matrix and keypad.
// A frame word uses the same layout as the keypad pad word.
package led_matrix_pkg;

    localparam int unsigned ROWS    = 4;
    localparam int unsigned COLS    = 4;
    localparam int unsigned FRAME_W = 16;

    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam int unsigned COL_W = $clog2(COLS);
    localparam int unsigned BIT_W = $clog2(FRAME_W);

    typedef logic [ROW_W-1:0] row_idx_t;
    typedef logic [COL_W-1:0] col_idx_t;
    typedef logic [BIT_W-1:0] bit_idx_t;

    // Row 0 occupies the top nibble, and column 0 is the MSB of each nibble.
    function automatic bit_idx_t tile_bit(input row_idx_t row, input col_idx_t col);
        return bit_idx_t'(FRAME_W - 1) - bit_idx_t'(COLS) * bit_idx_t'(row) - bit_idx_t'(col);
    endfunction

endpackage

// File: rtl/row_timer.sv
// Row slot timer: this module counts cycles within a row slot and steps the scanned row.
// It also flags the blanking phase, the end of each slot, and the end of each frame.
module row_timer
    import led_matrix_pkg::*;
#(
    parameter int unsigned ROW_CYCLES   = 125000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic     clk_i,
    input  logic     reset_i,
    output row_idx_t row_o,
    output logic     blank_c,
    output logic     row_end_c,
    output logic     frame_end_c
);

    localparam int unsigned CNT_W = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    row_idx_t         row_q, row_d;

    always_comb begin
        row_end_c   = (cnt_q == CNT_W'(ROW_CYCLES - 1));
        blank_c     = (cnt_q < CNT_W'(BLANK_CYCLES));
        frame_end_c = row_end_c && (row_q == row_idx_t'(ROWS - 1));
        cnt_d       = row_end_c ? '0 : cnt_q + CNT_W'(1);
        row_d       = row_end_c ? row_q + row_idx_t'(1) : row_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
            row_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            row_q <= row_d;
        end
    end

    assign row_o = row_q;

endmodule

// File: rtl/led_matrix_driver.sv
// Time-multiplexed 4x4 LED matrix driver with a double-buffered frame input.
// The buffers swap only at the frame boundary, so a displayed frame never tears.
module led_matrix_driver
    import led_matrix_pkg::*;
#(
    parameter int unsigned ROW_CYCLES   = 125000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               enable,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic               frame_valid,
    output logic               frame_ready,
    output logic [ROWS-1:0]    rows,
    output logic [COLS-1:0]    cols,
    output logic               frame_start
);

    row_idx_t row;
    logic     blank;
    logic     frame_end;
    logic     unused_row_end;

    row_timer #(
        .ROW_CYCLES  (ROW_CYCLES),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_row_timer (
        .clk_i      (CLOCK_50),
        .reset_i    (reset),
        .row_o      (row),
        .blank_c    (blank),
        .row_end_c  (unused_row_end),
        .frame_end_c(frame_end)
    );

    logic [ROWS-1:0]    rows_q, rows_d;
    logic [COLS-1:0]    cols_q, cols_d;
    logic               frame_start_q, frame_start_d;
    logic [FRAME_W-1:0] active_q, active_d;
    logic [FRAME_W-1:0] shadow_q, shadow_d;
    logic               shadow_full_q, shadow_full_d;

    // Next drive values. The matrix is dark while blanking or when disabled.
    always_comb begin
        rows_d = '1;
        cols_d = '0;
        if (!blank && enable) begin
            rows_d[row] = 1'b0;
            for (int c = 0; c < int'(COLS); c++) begin
                cols_d[c] = active_q[tile_bit(row, col_idx_t'(c))];
            end
        end
    end

    // Shadow/active buffering. A full shadow blocks accepts, so a swap and an accept never coincide.
    always_comb begin
        active_d      = active_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        frame_start_d = frame_end;
        if (frame_end && shadow_full_q) begin
            active_d      = shadow_q;
            shadow_full_d = 1'b0;
        end else if (frame_valid && !shadow_full_q) begin
            shadow_d      = frame_in;
            shadow_full_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            rows_q        <= '1;
            cols_q        <= '0;
            frame_start_q <= 1'b0;
            active_q      <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
        end else begin
            rows_q        <= rows_d;
            cols_q        <= cols_d;
            frame_start_q <= frame_start_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
        end
    end

    assign frame_ready = !shadow_full_q;
    assign rows        = rows_q;
    assign cols        = cols_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_matrix_driver.sv
// Directed self-checking bench for led_matrix_driver with ROW_CYCLES=8 and BLANK_CYCLES=2.
// Variable cyc counts the clock edges since reset release.
module tb_led_matrix_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [15:0] frame_in = 16'h0000;
    logic        frame_valid = 1'b0;
    logic        frame_ready;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic        frame_start;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    led_matrix_driver #(
        .ROW_CYCLES  (8),
        .BLANK_CYCLES(2)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .enable     (enable),
        .frame_in   (frame_in),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .rows       (rows),
        .cols       (cols),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Hand-derived column patterns, where each entry is indexed by row.
    localparam logic [3:0][3:0] T_ZERO = '0;
    localparam logic [3:0][3:0] T_DIAG = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
    localparam logic [3:0][3:0] T_FULL = {4'b1111, 4'b1111, 4'b1111, 4'b1111};
    localparam logic [3:0][3:0] T_0F0F = {4'b1111, 4'b0000, 4'b1111, 4'b0000};
    localparam logic [3:0][3:0] T_F000 = {4'b0000, 4'b0000, 4'b0000, 4'b1111};
    localparam logic [3:0][3:0] T_000F = {4'b1111, 4'b0000, 4'b0000, 4'b0000};

    // Outputs after edge k reflect scan position p = k-1.
    function automatic logic [3:0] exp_rows(input int k);
        int p;
        p = k - 1;
        if (p % 8 < 2) return 4'b1111;
        case ((p / 8) % 4)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    function automatic logic [3:0] exp_cols(input int k, input logic [3:0][3:0] tbl);
        int p;
        p = k - 1;
        if (p % 8 < 2) return 4'b0000;
        return tbl[2'((p / 8) % 4)];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset       = 1'b1;
        frame_valid = 1'b0;
        enable      = 1'b1;
        repeat (n) step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        total++; if (rows !== 4'b1111) begin bad++; $display("FAIL reset_rows got=%b exp=1111", rows); end
        total++; if (cols !== 4'b0000) begin bad++; $display("FAIL reset_cols got=%b exp=0000", cols); end
        total++; if (frame_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", frame_ready); end
        total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fstart got=%b exp=0", frame_start); end
        reset = 1'b0;
        step();
        total++; if (rows !== 4'b1111) begin bad++; $display("FAIL rel1_rows got=%b exp=1111", rows); end
        step();
        total++; if (rows !== 4'b1111) begin bad++; $display("FAIL rel2_rows got=%b exp=1111", rows); end
        step();
        total++; if (rows !== 4'b1110) begin bad++; $display("FAIL rel3_rows got=%b exp=1110", rows); end
        total++; if (cols !== 4'b0000) begin bad++; $display("FAIL rel3_cols got=%b exp=0000", cols); end
        total++; if (frame_ready !== 1'b1) begin bad++; $display("FAIL rel3_ready got=%b exp=1", frame_ready); end
    endtask

    task automatic test_single_frame();
        do_reset(2);
        frame_in    = 16'h8421;
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        while (cyc < 31) begin
            total++; if (frame_ready !== 1'b0) begin bad++; $display("FAIL single_ready_low k=%0d got=%b exp=0", cyc, frame_ready); end
            step();
        end
        step();
        total++; if (frame_ready !== 1'b1) begin bad++; $display("FAIL single_ready_rise got=%b exp=1", frame_ready); end
        total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL single_fstart got=%b exp=1", frame_start); end
        repeat (32) begin
            step();
            total++;
            if (rows !== exp_rows(cyc) || cols !== exp_cols(cyc, T_DIAG)) begin
                bad++; $display("FAIL single_scan k=%0d got=%b/%b exp=%b/%b", cyc, rows, cols, exp_rows(cyc), exp_cols(cyc, T_DIAG));
            end
            total++; if (frame_start !== (cyc % 32 == 0)) begin bad++; $display("FAIL single_fstart k=%0d got=%b", cyc, frame_start); end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0][3:0] tbl;
        do_reset(2);
        frame_in    = 16'hFFFF;
        frame_valid = 1'b1;
        step();
        frame_in = 16'h0F0F;
        while (cyc < 31) begin
            step();
            total++; if (frame_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall k=%0d got=%b exp=0", cyc, frame_ready); end
        end
        step();
        total++; if (frame_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_after_swap got=%b exp=1", frame_ready); end
        step();
        total++; if (frame_ready !== 1'b0) begin bad++; $display("FAIL b2b_second_accept got=%b exp=0", frame_ready); end
        frame_valid = 1'b0;
        while (cyc < 96) begin
            step();
            tbl = (cyc <= 64) ? T_FULL : T_0F0F;
            total++;
            if (rows !== exp_rows(cyc) || cols !== exp_cols(cyc, tbl)) begin
                bad++; $display("FAIL b2b_scan k=%0d got=%b/%b exp=%b/%b", cyc, rows, cols, exp_rows(cyc), exp_cols(cyc, tbl));
            end
        end
    endtask

    task automatic test_tear();
        logic [3:0][3:0] tbl;
        do_reset(2);
        frame_in    = 16'hF000;
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        while (cyc < 96) begin
            step();
            tbl = (cyc <= 32) ? T_ZERO : ((cyc <= 64) ? T_F000 : T_000F);
            total++;
            if (rows !== exp_rows(cyc) || cols !== exp_cols(cyc, tbl)) begin
                bad++; $display("FAIL tear_scan k=%0d got=%b/%b exp=%b/%b", cyc, rows, cols, exp_rows(cyc), exp_cols(cyc, tbl));
            end
            if (cyc == 45) begin
                total++; if (frame_ready !== 1'b0) begin bad++; $display("FAIL tear_accept got=%b exp=0", frame_ready); end
                frame_valid = 1'b0;
            end
            if (cyc == 44) begin
                frame_in    = 16'h000F;
                frame_valid = 1'b1;
            end
        end
    endtask

    task automatic test_enable();
        logic [3:0] er;
        logic [3:0] ec;
        do_reset(2);
        frame_in    = 16'hFFFF;
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        while (cyc < 64) begin
            step();
            if (cyc >= 43 && cyc <= 47) begin
                er = 4'b1111;
                ec = 4'b0000;
            end else begin
                er = exp_rows(cyc);
                ec = exp_cols(cyc, (cyc <= 32) ? T_ZERO : T_FULL);
            end
            total++;
            if (rows !== er || cols !== ec) begin
                bad++; $display("FAIL enable_scan k=%0d got=%b/%b exp=%b/%b", cyc, rows, cols, er, ec);
            end
            if (cyc == 42) enable = 1'b0;
            if (cyc == 47) enable = 1'b1;
        end
    endtask

    task automatic test_reset_mid();
        do_reset(2);
        frame_in    = 16'hFFFF;
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        while (cyc < 51) begin
            step();
            total++;
            if (rows !== exp_rows(cyc) || cols !== exp_cols(cyc, (cyc <= 32) ? T_ZERO : T_FULL)) begin
                bad++; $display("FAIL rmid_pre k=%0d got=%b/%b", cyc, rows, cols);
            end
            if (cyc == 37) frame_valid = 1'b0;
            if (cyc == 36) begin
                frame_in    = 16'h000F;
                frame_valid = 1'b1;
            end
        end
        total++; if (frame_ready !== 1'b0) begin bad++; $display("FAIL rmid_pending got=%b exp=0", frame_ready); end
        reset = 1'b1;
        step();
        total++; if (rows !== 4'b1111 || cols !== 4'b0000) begin bad++; $display("FAIL rmid_dark got=%b/%b exp=1111/0000", rows, cols); end
        total++; if (frame_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", frame_ready); end
        step();
        reset = 1'b0;
        repeat (70) begin
            step();
            total++;
            if (rows !== exp_rows(cyc) || cols !== 4'b0000 || frame_ready !== 1'b1) begin
                bad++; $display("FAIL rmid_post k=%0d got=%b/%b rdy=%b exp=%b/0000 rdy=1", cyc, rows, cols, frame_ready, exp_rows(cyc));
            end
            total++; if (frame_start !== (cyc % 32 == 0)) begin bad++; $display("FAIL rmid_fstart k=%0d got=%b", cyc, frame_start); end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_tear();
        test_enable();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
